// File: rtl/tg_poll_seq_if.sv
// TG request bus between the poll sequencer and tg_axi_master.
// Carries one request (write or read) plus its completion pulse and read data.
// master = request issuer (sequencer), slave = request executor (AXI master).
interface tg_poll_seq_if #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32
);
  logic                          wr_req;
  logic                          rd_req;
  logic [AXI_ADDR_WIDTH-1:0]     addr;
  logic [AXI_DATA_WIDTH-1:0]     wdata;
  logic [AXI_DATA_WIDTH/8-1:0]   wstrb;
  logic                          op_ack;
  logic [AXI_DATA_WIDTH-1:0]     rdata;

  modport master (
    output wr_req, rd_req, addr, wdata, wstrb,
    input  op_ack, rdata
  );

  modport slave (
    input  wr_req, rd_req, addr, wdata, wstrb,
    output op_ack, rdata
  );
endinterface

// File: rtl/tg_poll_seq.sv
// Status-poll sequencer: after start, reads POLL_ADDR until a status field matches A or B.
// Latency: start->rd_req START_DELAY+2, op_ack->done 2, failed check->next rd_req POLL_INTERVAL+2.
// Backpressure: one read outstanding at a time; waits for op_ack up to ACK_TIMEOUT cycles.
module tg_poll_seq #(
  parameter int unsigned                 AXI_ADDR_WIDTH = 32,
  parameter int unsigned                 AXI_DATA_WIDTH = 32,
  parameter logic [AXI_ADDR_WIDTH-1:0]   POLL_ADDR      = '0,
  parameter int unsigned                 FIELD_LSB      = 8,
  parameter int unsigned                 FIELD_WIDTH    = 8,
  parameter logic [FIELD_WIDTH-1:0]      MATCH_A        = 'h09,
  parameter logic [FIELD_WIDTH-1:0]      MATCH_B        = 'h0A,
  parameter int unsigned                 START_DELAY    = 100,
  parameter int unsigned                 POLL_INTERVAL  = 5000,
  parameter int unsigned                 MAX_POLLS      = 1024,
  parameter int unsigned                 ACK_TIMEOUT    = 4096
) (
  input  logic                       m_axi_aclk,
  input  logic                       m_axi_areset,
  input  logic                       start,
  tg_poll_seq_if.master              tg,
  output logic                       busy,
  output logic                       done,
  output logic                       fail,
  output logic                       ack_timeout,
  output logic [15:0]                poll_count,
  output logic [AXI_DATA_WIDTH-1:0]  last_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_WAIT,
    S_ISSUE,
    S_WAIT_ACK,
    S_CHECK,
    S_INTERVAL,
    S_DONE,
    S_FAIL
  } state_e;

  state_e                      state_q, state_d;
  logic [31:0]                 cnt_q, cnt_d;       // shared delay / timeout / interval counter
  logic [31:0]                 polls_q, polls_d;   // unsaturated read count for the limit compare
  logic [15:0]                 pc_q, pc_d;         // saturating read count reported outward
  logic                        done_q, done_d;
  logic                        fail_q, fail_d;
  logic                        to_q, to_d;
  logic [AXI_DATA_WIDTH-1:0]   last_q, last_d;
  logic [FIELD_WIDTH-1:0]      field;

  assign field = last_q[FIELD_LSB +: FIELD_WIDTH];

  // Request bus: read-only, the address is only presented while a poll run is active.
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_FAIL);
  assign tg.rd_req   = (state_q == S_ISSUE);
  assign tg.addr     = busy ? POLL_ADDR : '0;
  assign tg.wr_req   = 1'b0;
  assign tg.wdata    = '0;
  assign tg.wstrb    = '0;

  assign done        = done_q;
  assign fail        = fail_q;
  assign ack_timeout = to_q;
  assign poll_count  = pc_q;
  assign last_rdata  = last_q;

  // Next-state and datapath updates for the poll loop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    polls_d = polls_q;
    pc_d    = pc_q;
    done_d  = done_q;
    fail_d  = fail_q;
    to_d    = to_q;
    last_d  = last_q;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start) begin
          done_d  = 1'b0;
          fail_d  = 1'b0;
          to_d    = 1'b0;
          pc_d    = '0;
          polls_d = '0;
          cnt_d   = 32'(START_DELAY);
          state_d = S_START_WAIT;
        end
      end

      S_START_WAIT, S_INTERVAL: begin
        // Leave one cycle after the counter hits zero, so a zero load still costs a cycle.
        if (cnt_q == 32'd0) begin
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      S_ISSUE: begin
        polls_d = polls_q + 32'd1;
        pc_d    = (pc_q == 16'hFFFF) ? pc_q : pc_q + 16'd1;
        cnt_d   = 32'(ACK_TIMEOUT);
        state_d = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        // Ack is checked first so an ack on the final waiting cycle is still accepted.
        // The counter is loaded with ACK_TIMEOUT and expires when it would reach zero,
        // giving exactly ACK_TIMEOUT cycles of waiting.
        if (tg.op_ack) begin
          last_d  = tg.rdata;
          state_d = S_CHECK;
        end else if (cnt_q <= 32'd1) begin
          fail_d  = 1'b1;
          to_d    = 1'b1;
          state_d = S_FAIL;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      S_CHECK: begin
        if ((field == MATCH_A) || (field == MATCH_B)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if ((MAX_POLLS != 0) && (polls_q == 32'(MAX_POLLS))) begin
          fail_d  = 1'b1;
          state_d = S_FAIL;
        end else begin
          cnt_d   = 32'(POLL_INTERVAL);
          state_d = S_INTERVAL;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any outstanding read.
  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      polls_q <= '0;
      pc_q    <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      polls_q <= polls_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_tg_poll_seq.sv
// Bench for tg_poll_seq: directed poll scenarios against a cycle-timestamp model.
// The model predicts every output each cycle from event times (start, rd, ack, check).
// A negedge compare process checks all outputs; the driver adds literal spot checks.
module tb_tg_poll_seq;

  localparam int SD = 4;    // start delay
  localparam int PI = 10;   // poll interval
  localparam int MP = 3;    // max polls
  localparam int AT = 16;   // ack timeout
  localparam logic [31:0] POLL_A = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, fail, ack_to;
  logic [15:0] pc;
  logic [31:0] last;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  tg_poll_seq_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) tg ();

  tg_poll_seq #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .POLL_ADDR(POLL_A),
    .FIELD_LSB(8), .FIELD_WIDTH(8), .MATCH_A(8'h09), .MATCH_B(8'h0A),
    .START_DELAY(SD), .POLL_INTERVAL(PI), .MAX_POLLS(MP), .ACK_TIMEOUT(AT)
  ) dut (
    .m_axi_aclk   (clk),
    .m_axi_areset (rst),
    .start        (start),
    .tg           (tg),
    .busy         (busy),
    .done         (done),
    .fail         (fail),
    .ack_timeout  (ack_to),
    .poll_count   (pc),
    .last_rdata   (last)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- model: event times in cycle numbers ----------------
  // Cycle n is the period after the n-th rising edge.
  int          m_rd_at  = -1;   // cycle in which rd_req is due
  int          m_lo     = -1;   // first cycle an ack is accepted
  int          m_hi     = -1;   // last cycle an ack is accepted
  int          m_chk_at = -1;   // cycle in which the status check happens
  bit          m_busy = 0, m_done = 0, m_fail = 0, m_to = 0;
  int          m_pc = 0, m_polls = 0;
  logic [31:0] m_last = '0;

  initial begin
    int e, prev;
    logic [7:0] fld;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      e = cyc;
      prev = e - 1;
      if (rst) begin
        m_rd_at = -1; m_lo = -1; m_hi = -1; m_chk_at = -1;
        m_busy = 0; m_done = 0; m_fail = 0; m_to = 0;
        m_pc = 0; m_polls = 0; m_last = '0;
      end else if (!m_busy) begin
        if (start) begin
          m_done = 0; m_fail = 0; m_to = 0; m_pc = 0; m_polls = 0;
          m_busy = 1;
          m_rd_at = prev + SD + 2;
        end
      end else if (prev == m_rd_at) begin
        m_polls++;
        if (m_pc < 65535) m_pc++;
        m_rd_at = -1;
        m_lo = prev + 1;
        m_hi = prev + AT;
      end else if (m_lo >= 0) begin
        if (tg.op_ack) begin
          m_last = tg.rdata;
          m_chk_at = e;
          m_lo = -1;
        end else if (prev == m_hi) begin
          m_fail = 1; m_to = 1; m_busy = 0; m_lo = -1;
        end
      end else if (prev == m_chk_at) begin
        fld = m_last[15:8];
        m_chk_at = -1;
        if (fld == 8'h09 || fld == 8'h0A) begin
          m_done = 1; m_busy = 0;
        end else if (m_polls == MP) begin
          m_fail = 1; m_busy = 0;
        end else begin
          m_rd_at = prev + PI + 2;
        end
      end
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        chk("rd_req",      32'(tg.rd_req), 32'(m_rd_at == cyc));
        chk("addr",        tg.addr,        m_busy ? POLL_A : 32'h0);
        chk("wr_req",      32'(tg.wr_req), 32'h0);
        chk("wdata",       tg.wdata,       32'h0);
        chk("wstrb",       32'(tg.wstrb),  32'h0);
        chk("busy",        32'(busy),      32'(m_busy));
        chk("done",        32'(done),      32'(m_done));
        chk("fail",        32'(fail),      32'(m_fail));
        chk("ack_timeout", 32'(ack_to),    32'(m_to));
        chk("poll_count",  32'(pc),        32'(m_pc));
        chk("last_rdata",  last,           m_last);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(output int s);
    start = 1'b1;
    s = cyc;
    tick();
    start = 1'b0;
  endtask

  // Returns the cycle in which rd_req is seen; a missing request counts as a failure.
  task automatic wait_rd(input string nm, output int r);
    int n = 0;
    while (!tg.rd_req && n < 60) begin
      tick();
      n++;
    end
    if (!tg.rd_req) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s no rd_req within 60 cycles (cyc=%0d)", nm, cyc);
    end
    r = cyc;
  endtask

  // Drives op_ack k cycles after the current cycle; returns the ack cycle.
  task automatic do_ack(input int k, input logic [31:0] d, output int a);
    repeat (k) tick();
    tg.op_ack = 1'b1;
    tg.rdata  = d;
    a = cyc;
    tick();
    tg.op_ack = 1'b0;
    tg.rdata  = '0;
  endtask

  initial begin
    int s, r, r2, a, seen;
    tg.op_ack = 1'b0;
    tg.rdata  = '0;

    // Reset held 5 cycles: everything quiet and zero.
    repeat (5) tick();
    chk("rst_busy",  32'(busy),      32'h0);
    chk("rst_done",  32'(done),      32'h0);
    chk("rst_fail",  32'(fail),      32'h0);
    chk("rst_pc",    32'(pc),        32'h0);
    chk("rst_rdreq", 32'(tg.rd_req), 32'h0);
    rst = 1'b0;
    tick();

    // 1: single poll, immediate match on 0x09.
    pulse_start(s);
    wait_rd("t1", r);
    chk("t1_start_to_rd", 32'(r - s), 32'd6);
    chk("t1_addr", tg.addr, 32'h0);
    do_ack(3, 32'h0000_0900, a);
    chk("t1_done_early", 32'(done), 32'h0);
    tick();
    chk("t1_ack_to_done", 32'(cyc - a), 32'd2);
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_pc",   32'(pc),   32'd1);
    chk("t1_last", last,      32'h0000_0900);
    repeat (3) tick();

    // 2: two misses then a match on 0x0A.
    pulse_start(s);
    wait_rd("t2a", r);
    do_ack(3, 32'h0000_0100, a);
    wait_rd("t2b", r2);
    chk("t2_gap1", 32'(r2 - r), 32'd16);   // ack +3, check +1, interval path 12
    r = r2;
    do_ack(1, 32'h0000_0100, a);
    wait_rd("t2c", r2);
    chk("t2_gap2", 32'(r2 - r), 32'd14);
    do_ack(2, 32'h0000_0A00, a);
    tick();
    chk("t2_done", 32'(done), 32'h1);
    chk("t2_pc",   32'(pc),   32'd3);
    repeat (3) tick();

    // 3: never matches -> poll limit after 3 reads, no 4th read.
    pulse_start(s);
    for (int i = 0; i < 3; i++) begin
      wait_rd("t3", r);
      do_ack(2, 32'h0000_0B00, a);
    end
    tick();
    chk("t3_fail", 32'(fail),   32'h1);
    chk("t3_to",   32'(ack_to), 32'h0);
    chk("t3_pc",   32'(pc),     32'd3);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      if (tg.rd_req) seen++;
      tick();
    end
    chk("t3_no_4th_rd", 32'(seen), 32'd0);

    // 4: ack withheld -> timeout after 16 waiting cycles; stray ack afterwards ignored.
    pulse_start(s);
    wait_rd("t4", r);
    repeat (16) tick();
    chk("t4_not_yet", 32'(fail), 32'h0);
    tick();
    chk("t4_fail", 32'(fail),   32'h1);
    chk("t4_to",   32'(ack_to), 32'h1);
    do_ack(2, 32'h0000_0900, a);
    tick();
    chk("t4_stray_done", 32'(done), 32'h0);
    chk("t4_stray_last", last,      32'h0000_0B00);
    chk("t4_stray_fail", 32'(fail), 32'h1);

    // 4b: ack on the last waiting cycle wins over the timeout.
    pulse_start(s);
    wait_rd("t4b", r);
    do_ack(16, 32'h0000_0A00, a);
    tick();
    chk("t4b_done", 32'(done),   32'h1);
    chk("t4b_to",   32'(ack_to), 32'h0);
    repeat (2) tick();

    // 5: reset in WAIT_ACK, stray ack in IDLE, then clean restart.
    pulse_start(s);
    wait_rd("t5", r);
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_last", last,      32'h0);
    do_ack(1, 32'h0000_0900, a);
    tick();
    chk("t5_idle_done", 32'(done), 32'h0);
    chk("t5_idle_last", last,      32'h0);
    pulse_start(s);
    wait_rd("t5b", r);
    chk("t5_restart_lat", 32'(r - s), 32'd6);
    tick();
    chk("t5_pc", 32'(pc), 32'd1);
    do_ack(2, 32'h0000_0900, a);
    tick();
    chk("t5_done", 32'(done), 32'h1);
    chk("t5_last", last,      32'h0000_0900);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
